// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-through reads, a reset image that
// presets the stack pointer, and a per-register pending-write scoreboard for decode stalls.
module regfile_sb #(
    parameter int              XLEN    = 32,
    parameter int              NREG    = 32,
    parameter int              AW      = 5,
    parameter int              NRD     = 2,
    parameter int              SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = 'h2000_7000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            wb_live;
    logic            iss_live;

    // x0 is hardwired, so writes and issues aimed at it are discarded up front
    assign wb_live  = wb_en && wb_addr != '0;
    assign iss_live = iss_en && iss_addr != '0;

    // register array: reset image is all zero except the stack pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // next pending set: writeback clears, a new producer overrides it, flush clears everything
    always_comb begin
        pend_nxt = pend;
        if (wb_live)
            pend_nxt[wb_addr] = 1'b0;
        if (iss_live)
            pend_nxt[iss_addr] = 1'b1;
        if (flush)
            pend_nxt = '0;
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
    end

    // scoreboard state and its registered population count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            busy_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = rd_addr[k*AW +: AW];
        assign hit = wb_en && wb_addr == a;
        assign rd_data[k*XLEN +: XLEN] = (a == '0) ? '0 : hit ? wb_data : regs[a];
        assign rd_busy[k] = (a != '0) && pend[a] && !hit;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write, dual-read integer register file.
- Provides NRD combinational read ports with write-through bypass and one writeback port.
- Adds an asynchronous reset image with a configurable stack-pointer value.
- Adds a per-register pending-write scoreboard, which the decode stage uses for hazard stalls.
- Sits between decode (reads, issue marking) and writeback (writes, busy clear).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers including x0 (power of 2)
AW, 5, address width, log2(NREG)
NRD, 2, number of read ports (1..4)
SP_IDX, 2, index of the stack-pointer register
SP_INIT, 32'h2000_7000, reset value of register SP_IDX

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr  input  NRD*AW  read addresses, port k at [k*AW +: AW]
rd_data  output  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
rd_busy  output  NRD  port k's register has a pending write
wb_en  input  1  writeback enable
wb_addr  input  AW  writeback register index
wb_data  input  XLEN  writeback data
iss_en  input  1  mark destination register pending
iss_addr  input  AW  destination index being issued
flush  input  1  synchronous clear of all pending bits
busy_cnt  output  AW+1  number of registers currently pending

Behaviour:
Reset (rst_n low, asynchronous):
- All registers clear to 0, except register SP_IDX, which loads SP_INIT.
- All pending bits clear and busy_cnt = 0.
- Reset asserted mid-operation overrides any same-cycle write, issue or flush.
- After release, the first rising edge behaves normally.

x0:
- Reads as 0 on every port and is never pending (rd_busy = 0).
- Writes and issues to index 0 are ignored. busy_cnt does not count index 0.

Write:
- On a rising edge with wb_en = 1 and wb_addr != 0, reg[wb_addr] <= wb_data.

Read (combinational, zero latency):
- rd_data[k] = 0 if rd_addr[k] = 0.
- Otherwise rd_data[k] = wb_data if wb_en = 1 and wb_addr = rd_addr[k] (write-through bypass).
- Otherwise rd_data[k] = reg[rd_addr[k]].
- All ports are independent, and several ports may read the same address.

rd_busy[k]:
- Equals pend[rd_addr[k]], except 0 when a same-cycle wb_en to that address clears the bit (bypass makes the data valid).
- Exception: a same-cycle issue to that address does not change rd_busy this cycle; the pending bit takes effect next cycle.

Scoreboard update per edge, priority order:
1. flush = 1: all pend <= 0. Any same-cycle issue is dropped; any same-cycle write is still performed.
2. iss_en = 1 with iss_addr != 0: pend[iss_addr] <= 1.
3. wb_en = 1 with wb_addr != 0: pend[wb_addr] <= 0, unless the same address is issued this cycle, in which case it stays 1 because the new producer wins.

Other scoreboard rules:
- Issue to an already-pending register keeps it 1 (no nesting or counting).
- Writeback to a non-pending register is legal and leaves the bit 0.

busy_cnt:
- Registered; equals the population count of pend after the update.
- Range 0..NREG-1; no wrap is possible.

General:
- No X outputs for any address value.
- Every register has exactly one writer, so no arbitration is needed.

Test Plan:
- Reset check: pulse rst_n low mid-cycle while wb_en=1 to x5. Read x2 and x5 → 32'h2000_7000 and 0, busy_cnt=0, write lost.
- Write-through: wb_en=1, wb_addr=7, wb_data=32'hDEAD_BEEF, rd_addr port0=7, port1=7, same cycle. Both ports read DEAD_BEEF combinationally; after the edge reg7 = DEAD_BEEF.
- x0: write 32'h1234 to x0 and issue x0. Every port reads 0, rd_busy=0, busy_cnt unchanged.
- Scoreboard:
  - Issue x3, then x4. rd_busy on x3 = 1, busy_cnt=2.
  - Writeback x3. busy_cnt=1, and rd_busy(x3) = 0 already in the writeback cycle.
  - Issue and writeback x4 in the same cycle. x4 stays pending, busy_cnt=1.
- Flush: with x3, x9, x31 pending, assert flush together with iss_en to x10 and wb_en x9=32'h55. All pend = 0, busy_cnt=0, x10 not pending, reg9 = 32'h55.
- Parametrisation: NRD=4, XLEN=64. Four ports read x1, x2, x0, x1 after writing 64'hFFFF_0000_0000_0001 to x1. Ports return the x1 value, SP_INIT zero-extended to 64 bits, 0, and the x1 value.
